// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter and its burst generator.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W    = 11;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_BURST_LEN = 8;
  localparam int DEF_MAX_WAIT  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_PIPE = 2'd1,
    OWN_DISP = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_burst_gen.sv
// Display burst sequencer: accepts a burst in IDLE, then walks BURST_LEN consecutive
// word addresses (wrapping at the top of memory), advancing only on granted beats.
module dmem_burst_gen
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic              beat_grant_i,
  output state_e            state_o,
  output logic [ADDR_W-1:0] beat_addr_o,
  output logic              beat_last_o
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  beat_cnt_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = BURST;
      BURST:   if (beat_grant_i && beat_last_o) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      base_q     <= '0;
      beat_cnt_q <= '0;
    end else if (state_q == IDLE && start_i) begin
      base_q     <= base_i;
      beat_cnt_q <= '0;
    end else if (state_q == BURST && beat_grant_i) begin
      beat_cnt_q <= beat_cnt_q + CNT_W'(1);
    end
  end

  // Address arithmetic is ADDR_W wide, so 0x7FF + 1 wraps to 0x000 naturally.
  assign beat_addr_o = base_q + ADDR_W'(beat_cnt_q);
  assign beat_last_o = (beat_cnt_q == LAST_BEAT);
  assign state_o     = state_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: pipeline load/store has priority, display bursts
// are guaranteed a beat after MAX_WAIT consecutive denials; read data is routed back by owner tag.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int MAX_WAIT  = DEF_MAX_WAIT
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              pipe_req_i,
  input  logic              pipe_wr_i,
  input  logic [ADDR_W-1:0] pipe_addr_i,
  input  logic [DATA_W-1:0] pipe_wdata_i,
  output logic              stall_o,
  output logic              pipe_rvalid_o,
  output logic [DATA_W-1:0] pipe_rdata_o,
  input  logic              disp_req_i,
  input  logic [ADDR_W-1:0] disp_base_i,
  output logic              disp_busy_o,
  output logic              disp_rvalid_o,
  output logic [DATA_W-1:0] disp_rdata_o,
  output logic              disp_done_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int WAIT_W = $clog2(MAX_WAIT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

  state_e            burst_state;
  logic [ADDR_W-1:0] beat_addr;
  logic              beat_last;
  logic              in_burst;
  logic              force_disp;
  logic              pipe_grant;
  logic              disp_grant;
  logic [WAIT_W-1:0] wait_cnt_q;
  owner_e            owner_q, owner_d;
  logic              last_q;

  dmem_burst_gen #(
    .ADDR_W    (ADDR_W),
    .BURST_LEN (BURST_LEN)
  ) u_burst_gen (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .start_i      (disp_req_i),
    .base_i       (disp_base_i),
    .beat_grant_i (disp_grant),
    .state_o      (burst_state),
    .beat_addr_o  (beat_addr),
    .beat_last_o  (beat_last)
  );

  assign in_burst = (burst_state == BURST);

  // NOTE: every signal driven here gets a value before any branch, so no latch is inferred.
  always_comb begin
    force_disp  = in_burst && (wait_cnt_q == WAIT_SAT);
    pipe_grant  = pipe_req_i && !force_disp;
    disp_grant  = in_burst && !pipe_grant;
    stall_o     = pipe_req_i && !pipe_grant;
    mem_en_o    = pipe_grant || disp_grant;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    owner_d     = OWN_NONE;
    if (pipe_grant) begin
      mem_we_o    = pipe_wr_i;
      mem_addr_o  = pipe_addr_i;
      mem_wdata_o = pipe_wdata_i;
      owner_d     = pipe_wr_i ? OWN_NONE : OWN_PIPE;
    end else if (disp_grant) begin
      mem_addr_o  = beat_addr;
      owner_d     = OWN_DISP;
    end
  end

  // Starvation counter: consecutive burst cycles in which the display beat lost to the pipeline.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wait_cnt_q <= '0;
    end else if (!in_burst || disp_grant) begin
      wait_cnt_q <= '0;
    end else if (wait_cnt_q != WAIT_SAT) begin
      wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      owner_q <= OWN_NONE;
      last_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      last_q  <= disp_grant && beat_last;
    end
  end

  // Read data is zeroed outside its valid cycle so idle outputs never show stale memory.
  assign pipe_rvalid_o = (owner_q == OWN_PIPE);
  assign pipe_rdata_o  = pipe_rvalid_o ? mem_rdata_i : '0;
  assign disp_rvalid_o = (owner_q == OWN_DISP);
  assign disp_rdata_o  = disp_rvalid_o ? mem_rdata_i : '0;
  assign disp_done_o   = disp_rvalid_o && last_q;

  // Busy covers the final beat's return cycle, so it drops the cycle after the last rvalid.
  assign disp_busy_o   = in_burst || disp_rvalid_o;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vectors, burst/starvation/reset/collision
// sequences, then randomized traffic against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 32;
  localparam int BURST_LEN = 8;
  localparam int MAX_WAIT  = 4;
  localparam int MEM_WORDS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PIPE_HOLD_ADDR = 11'h030;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              pipe_req_i, pipe_wr_i;
  logic [ADDR_W-1:0] pipe_addr_i;
  logic [DATA_W-1:0] pipe_wdata_i;
  logic              stall_o, pipe_rvalid_o;
  logic [DATA_W-1:0] pipe_rdata_o;
  logic              disp_req_i;
  logic [ADDR_W-1:0] disp_base_i;
  logic              disp_busy_o, disp_rvalid_o, disp_done_o;
  logic [DATA_W-1:0] disp_rdata_o;
  logic              mem_en_o, mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  logic [DATA_W-1:0] mem     [MEM_WORDS];
  logic [DATA_W-1:0] ref_mem [MEM_WORDS];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .pipe_req_i(pipe_req_i), .pipe_wr_i(pipe_wr_i), .pipe_addr_i(pipe_addr_i),
    .pipe_wdata_i(pipe_wdata_i), .stall_o(stall_o), .pipe_rvalid_o(pipe_rvalid_o),
    .pipe_rdata_o(pipe_rdata_o), .disp_req_i(disp_req_i), .disp_base_i(disp_base_i),
    .disp_busy_o(disp_busy_o), .disp_rvalid_o(disp_rvalid_o), .disp_rdata_o(disp_rdata_o),
    .disp_done_o(disp_done_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  function automatic logic [DATA_W-1:0] init_val(input int a);
    return 32'hC0DE_0000 | DATA_W'(a);
  endfunction

  // Single-port synchronous memory, read data valid one cycle after the read.
  initial begin
    mem_rdata_i = '0;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = init_val(i);
    forever begin
      @(posedge clk_i);
      if (mem_en_o) begin
        if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
        else          mem_rdata_i     <= mem[mem_addr_o];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {stall_o, pipe_rvalid_o, disp_busy_o, disp_rvalid_o, disp_done_o,
                 mem_en_o, mem_we_o, pipe_rdata_o, disp_rdata_o}, '0);
  endtask

  // One full burst; with pipe_hold the pipeline requests reads every cycle, so the
  // display should win exactly every (MAX_WAIT+1)-th burst cycle.
  task automatic directed_burst(input logic [ADDR_W-1:0] base, input bit pipe_hold);
    int beat, c, prev_disp;
    bit prev_pipe_rd, exp_disp;
    logic [ADDR_W-1:0] exp_addr;
    beat = 0; c = 0; prev_disp = -1;
    next_cycle();
    disp_req_i = 1'b1; disp_base_i = base;
    pipe_req_i = pipe_hold; pipe_wr_i = 1'b0; pipe_addr_i = PIPE_HOLD_ADDR;
    mid();
    check("accept_busy", disp_busy_o, 0);
    check("accept_stall", stall_o, 0);
    prev_pipe_rd = pipe_hold;
    next_cycle();
    disp_req_i = 1'b0;
    while (beat < BURST_LEN || prev_disp >= 0) begin
      exp_disp = (beat < BURST_LEN) && (!pipe_hold || (c % (MAX_WAIT + 1)) == MAX_WAIT);
      mid();
      check("burst_busy", disp_busy_o, 1);
      check("disp_rvalid", disp_rvalid_o, prev_disp >= 0);
      if (prev_disp >= 0) begin
        exp_addr = base + ADDR_W'(prev_disp);
        check("disp_rdata", disp_rdata_o, ref_mem[exp_addr]);
        check("disp_done", disp_done_o, prev_disp == BURST_LEN - 1);
      end
      check("pipe_rvalid", pipe_rvalid_o, prev_pipe_rd);
      if (prev_pipe_rd) check("pipe_rdata", pipe_rdata_o, ref_mem[PIPE_HOLD_ADDR]);
      if (exp_disp) begin
        exp_addr = base + ADDR_W'(beat);
        check("disp_addr", mem_addr_o, exp_addr);
        check("disp_en_we", {mem_en_o, mem_we_o}, 2'b10);
        check("forced_stall", stall_o, pipe_hold);
      end else begin
        check("pipe_en", mem_en_o, pipe_hold);
        check("pipe_stall", stall_o, 0);
      end
      prev_disp    = exp_disp ? beat : -1;
      prev_pipe_rd = pipe_hold && !exp_disp;
      if (exp_disp) beat++;
      c++;
      next_cycle();
    end
    pipe_req_i = 1'b0;
    mid();
    check("busy_drop", disp_busy_o, 0);
    check("disp_rvalid_end", disp_rvalid_o, 0);
    check("pipe_rvalid_end", pipe_rvalid_o, prev_pipe_rd);
    if (prev_pipe_rd) check("pipe_rdata_end", pipe_rdata_o, ref_mem[PIPE_HOLD_ADDR]);
  endtask

  // Random traffic. Pipeline addresses stay below 0x400 and display bases above, so
  // display expectations come straight from the reference memory image.
  task automatic random_phase(input int n_cycles);
    bit m_burst, exp_pr_v, exp_dr_v, exp_dr_last, held, prev_stall, pipe_acc, disp_beat;
    logic [ADDR_W-1:0] m_base, a;
    logic [DATA_W-1:0] exp_pr_d, exp_dr_d;
    int m_issued, m_deny;
    m_burst = 0; exp_pr_v = 0; exp_dr_v = 0; exp_dr_last = 0; held = 0; prev_stall = 0;
    m_base = '0; exp_pr_d = '0; exp_dr_d = '0; m_issued = 0; m_deny = 0;
    for (int cyc = 0; cyc < n_cycles; cyc++) begin
      next_cycle();
      if (!held) begin
        pipe_req_i   = ($urandom_range(0, 9) < 6);
        pipe_wr_i    = 1'($urandom_range(0, 1));
        pipe_addr_i  = ADDR_W'($urandom_range(0, 'h3FF));
        pipe_wdata_i = $urandom;
      end
      disp_req_i  = ($urandom_range(0, 9) < 3);
      disp_base_i = ADDR_W'($urandom_range('h400, 'h7F7));
      mid();
      pipe_acc  = pipe_req_i && !stall_o;
      disp_beat = mem_en_o && !pipe_acc;
      check("r_pipe_rvalid", pipe_rvalid_o, exp_pr_v);
      if (exp_pr_v) check("r_pipe_rdata", pipe_rdata_o, exp_pr_d);
      check("r_disp_rvalid", disp_rvalid_o, exp_dr_v);
      check("r_disp_done", disp_done_o, exp_dr_v && exp_dr_last);
      if (exp_dr_v) check("r_disp_rdata", disp_rdata_o, exp_dr_d);
      check("r_busy", disp_busy_o, m_burst || exp_dr_v);
      if (stall_o) check("r_stall_run", prev_stall, 0);
      if (!pipe_req_i) check("r_no_req_stall", stall_o, 0);
      if (pipe_acc) begin
        check("r_pipe_bus", {mem_en_o, mem_we_o, mem_addr_o}, {1'b1, pipe_wr_i, pipe_addr_i});
        if (pipe_wr_i) check("r_pipe_wdata", mem_wdata_o, pipe_wdata_i);
      end
      exp_pr_v = pipe_acc && !pipe_wr_i;
      exp_pr_d = ref_mem[pipe_addr_i];
      if (pipe_acc && pipe_wr_i) ref_mem[pipe_addr_i] = pipe_wdata_i;
      exp_dr_v = 1'b0;
      exp_dr_last = 1'b0;
      if (m_burst) begin
        if (disp_beat) begin
          a = m_base + ADDR_W'(m_issued);
          check("r_disp_bus", {mem_we_o, mem_addr_o}, {1'b0, a});
          exp_dr_v    = 1'b1;
          exp_dr_d    = ref_mem[a];
          exp_dr_last = (m_issued == BURST_LEN - 1);
          m_issued++;
          m_deny = 0;
          if (m_issued == BURST_LEN) m_burst = 1'b0;
        end else begin
          m_deny++;
          check("r_starve", m_deny <= MAX_WAIT, 1);
          check("r_work_cons", pipe_acc, 1);
        end
      end else begin
        check("r_idle_no_disp", disp_beat, 0);
        if (disp_req_i) begin
          m_burst = 1'b1; m_base = disp_base_i; m_issued = 0; m_deny = 0;
        end
      end
      prev_stall = stall_o;
      held       = pipe_req_i && stall_o;
    end
  endtask

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp_rdata;
  } pipe_vec_t;

  initial begin
    pipe_vec_t vecs [8];
    bit prev_rd;
    logic [DATA_W-1:0] prev_exp;
    int done_cnt;

    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_val(i);
    vecs[0] = '{1'b0, 11'h010, 32'h0,         init_val('h010)};
    vecs[1] = '{1'b1, 11'h020, 32'hDEADBEEF,  32'h0};
    vecs[2] = '{1'b0, 11'h020, 32'h0,         32'hDEADBEEF};
    vecs[3] = '{1'b1, 11'h3FF, 32'h12345678,  32'h0};
    vecs[4] = '{1'b0, 11'h000, 32'h0,         init_val('h000)};
    vecs[5] = '{1'b0, 11'h3FF, 32'h0,         32'h12345678};
    vecs[6] = '{1'b1, 11'h010, 32'hA5A5A5A5,  32'h0};
    vecs[7] = '{1'b0, 11'h010, 32'h0,         32'hA5A5A5A5};

    reset_i = 1'b1;
    pipe_req_i = 1'b0; pipe_wr_i = 1'b0; pipe_addr_i = '0; pipe_wdata_i = '0;
    disp_req_i = 1'b0; disp_base_i = '0;
    mid();
    check_all_zero("reset_outputs");
    next_cycle();
    next_cycle();
    reset_i = 1'b0;
    mid();
    check_all_zero("post_reset_idle");

    // Pipeline-only traffic, back to back.
    prev_rd = 1'b0; prev_exp = '0;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      pipe_req_i = 1'b1; pipe_wr_i = vecs[i].wr;
      pipe_addr_i = vecs[i].addr; pipe_wdata_i = vecs[i].wdata;
      mid();
      check("pv_stall", stall_o, 0);
      check("pv_bus", {mem_en_o, mem_we_o, mem_addr_o}, {1'b1, vecs[i].wr, vecs[i].addr});
      if (vecs[i].wr) begin
        check("pv_wdata", mem_wdata_o, vecs[i].wdata);
        ref_mem[vecs[i].addr] = vecs[i].wdata;
      end
      check("pv_rvalid", pipe_rvalid_o, prev_rd);
      if (prev_rd) check("pv_rdata", pipe_rdata_o, prev_exp);
      prev_rd  = !vecs[i].wr;
      prev_exp = vecs[i].exp_rdata;
    end
    next_cycle();
    pipe_req_i = 1'b0;
    mid();
    check("pv_rvalid_last", pipe_rvalid_o, prev_rd);
    if (prev_rd) check("pv_rdata_last", pipe_rdata_o, prev_exp);
    check("pv_idle_en", mem_en_o, 0);

    directed_burst(11'h100, 1'b0);
    directed_burst(11'h7FC, 1'b0);
    directed_burst(11'h180, 1'b1);

    // Reset after the third display beat is issued.
    next_cycle();
    disp_req_i = 1'b1; disp_base_i = 11'h200;
    next_cycle();
    disp_req_i = 1'b0;
    next_cycle();
    next_cycle();
    mid();
    check("rst_third_beat", {mem_en_o, mem_addr_o}, {1'b1, 11'h202});
    next_cycle();
    reset_i = 1'b1;
    mid();
    check_all_zero("rst_mid_burst");
    next_cycle();
    mid();
    check_all_zero("rst_held");
    next_cycle();
    reset_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mid();
      check("rst_quiet", {disp_busy_o, disp_rvalid_o, disp_done_o, mem_en_o}, 4'b0000);
      next_cycle();
    end
    directed_burst(11'h208, 1'b0);

    // Same-address collision: pipeline write wins, display beat next cycle sees new data.
    next_cycle();
    disp_req_i = 1'b1; disp_base_i = 11'h050;
    next_cycle();
    disp_req_i = 1'b0;
    pipe_req_i = 1'b1; pipe_wr_i = 1'b1; pipe_addr_i = 11'h050; pipe_wdata_i = 32'hCAFEF00D;
    mid();
    check("col_stall", stall_o, 0);
    check("col_bus", {mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o}, {2'b11, 11'h050, 32'hCAFEF00D});
    ref_mem[11'h050] = 32'hCAFEF00D;
    next_cycle();
    pipe_req_i = 1'b0;
    mid();
    check("col_beat0", {mem_en_o, mem_we_o, mem_addr_o}, {2'b10, 11'h050});
    next_cycle();
    mid();
    check("col_rvalid", disp_rvalid_o, 1);
    check("col_rdata", disp_rdata_o, 32'hCAFEF00D);
    done_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      next_cycle();
      mid();
      if (disp_done_o) done_cnt++;
    end
    next_cycle();
    mid();
    check("col_busy_drop", disp_busy_o, 0);
    check("col_done_count", done_cnt, 1);

    random_phase(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipeline load/store path and the display refresh engine.
- The pipeline side consumes the execute-stage memory outputs: enable, write flag, 11-bit address and 32-bit data.
- The display side requests fixed-length read bursts.
- The block grants at most one memory access per cycle, routes read data back to its owner, and raises stall_o when the pipeline must hold its request.

Parameters:
- ADDR_W, 11, memory word-address width.
- DATA_W, 32, data width.
- BURST_LEN, 8, display beats per burst (power of two, >=2).
- MAX_WAIT, 4, consecutive denied display beats before the display is forced a grant.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- pipe_req_i  in  1  pipeline memory request (execute-stage mem_en)
- pipe_wr_i  in  1  1=write, 0=read
- pipe_addr_i  in  ADDR_W  pipeline address
- pipe_wdata_i  in  DATA_W  pipeline write data
- stall_o  out  1  pipeline must hold its request this cycle
- pipe_rvalid_o  out  1  pipeline read data valid
- pipe_rdata_o  out  DATA_W  pipeline read data
- disp_req_i  in  1  burst request, level
- disp_base_i  in  ADDR_W  burst start address
- disp_busy_o  out  1  burst in progress
- disp_rvalid_o  out  1  display beat data valid
- disp_rdata_o  out  DATA_W  display beat data
- disp_done_o  out  1  pulses with the final beat's rvalid
- mem_en_o  out  1  memory enable
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid one cycle after a read

Behaviour:
- Reset values: stall_o, pipe_rvalid_o, disp_busy_o, disp_rvalid_o, disp_done_o and mem_en_o/mem_we_o are 0. Rdata outputs are 0. State is IDLE and all counters are 0.
- Reset mid-burst aborts the burst. No rvalid or done is produced for beats in flight.
- FSM IDLE:
  - disp_req_i=1 latches base, clears beat_cnt and wait_cnt, and moves to BURST next cycle.
  - No display beats are issued in IDLE.
- FSM BURST:
  - disp_busy_o=1.
  - Each cycle a display beat is eligible at address (base+beat_cnt) mod 2^ADDR_W. The address wraps from 0x7FF to 0x000.
  - Once beat BURST_LEN-1 is issued, return to IDLE next cycle.
  - disp_busy_o drops in the cycle after the last rvalid.
  - disp_req_i is ignored while in BURST. A held request is re-accepted in IDLE.
- Grant is combinational, at most one per cycle:
  - If pipe_req_i=1 and not (BURST and wait_cnt==MAX_WAIT), the pipeline is granted.
  - Otherwise, if a display beat is eligible, the display is granted.
  - Otherwise there is no access.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, each BURST cycle a display beat is denied.
  - Clears on every display grant.
- stall_o = pipe_req_i & ~pipe_grant, combinational. The pipeline holds all pipe_* inputs stable while stall_o=1.
- A granted beat drives mem_en_o=1 and mem_we_o=pipe_wr_i (pipeline) or 0 (display), with the matching address and wdata. When nothing is granted, mem_en_o=0.
- Read return:
  - A registered owner tag selects the destination one cycle after a read grant: pipe_rvalid_o or disp_rvalid_o, each for one cycle, with rdata = mem_rdata_i.
  - Writes produce no response.
  - Read latency is exactly 1 cycle after grant.
- disp_done_o=1 together with the disp_rvalid_o of beat BURST_LEN-1.
- Ordering: display beats return in address order. Pipeline reads return in order.
- beat_cnt width is log2(BURST_LEN)+1. wait_cnt width is log2(MAX_WAIT)+1.

Decomposition:
- Package dmem_arb_pkg holds:
  - state enum {IDLE, BURST};
  - owner enum {OWN_NONE, OWN_PIPE, OWN_DISP};
  - ADDR_W/DATA_W defaults.
- One sub-module, dmem_burst_gen: base latch, beat_cnt, address generation, last-beat flag.
- The arbitration, starvation counter and return routing stay in the top.

Test Plan:
- Pipeline-only: read 0x010, then write 0x020=0xDEADBEEF, then read 0x020 -> stall_o stays 0, pipe_rvalid_o one cycle after each read, and the second read returns 0xDEADBEEF.
- Display-only burst, base 0x100 -> 8 consecutive reads of 0x100..0x107, 8 disp_rvalid_o, disp_done_o on the 8th, and disp_busy_o clear the next cycle.
- Wrap: base 0x7FC -> addresses 0x7FC,0x7FD,0x7FE,0x7FF,0x000,0x001,0x002,0x003.
- Starvation: pipe_req_i held continuously during a burst -> pipeline granted 4 cycles, then the display is forced one beat with stall_o=1 that cycle. The pattern repeats until all 8 beats complete, after which stall_o=0.
- Assert reset_i after the 3rd display beat is issued -> all outputs 0 immediately, no further disp_rvalid_o or disp_done_o, and a new burst is accepted cleanly after release.
- Pipeline write and display read to the same address 0x050 in the same cycle -> pipeline wins, and the display beat issued next cycle returns the new value.
